// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath
//
// Three-stage pipelined datapath: operand fetch (OF), execute (EX) and
// write-back (WB). It holds its own register file, function unit and the
// B / D / R source muxes. Micro-ops are accepted through a valid/ready
// handshake, and read-after-write hazards against in-flight writes are
// resolved in OF.
//
// Optional feature (compile-time macro DP_FORWARD_EN):
//   defined   : the EX result (ALU or PC writes) and the WB Reg_in value are
//               forwarded into OF. A load in EX whose destination is read by
//               the issuing op drops in_ready for exactly one cycle.
//   undefined : no forwarding. in_ready stays low while any matching write
//               is still in EX or WB (at most two stall cycles).
//   In both builds the register file is write-through: a read of the address
//   being written by WB in the same cycle returns the new value.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low (0 = reset)
//   in_valid     micro-op presented on the issue inputs
//   in_ready     OF can accept; transfer when in_valid & in_ready
//   we           micro-op writes register DA
//   MuxB_sel     0: B = reg[BA], 1: B = Constant_in
//   MuxD_sel     0: D = Data_in (load), 1: D = FU result
//   MuxR_sel     0: write PC_in, 1: write D
//   Sel          FU operation code
//   AA, BA, DA   A / B source and destination register addresses
//   PC_in        PC value, captured at issue
//   Constant_in  immediate, captured at issue
//   Data_in      memory read data, valid while the op is in WB
//   Addr_out     EX-stage FU result (memory address)
//   Data_out     EX-stage reg[BA] operand (store data)
//   mem_valid    EX stage holds a valid op
//   wb_valid     WB stage holds a valid op
//   wb_addr      destination of the WB op
//   C, V, N, Z   registered flags of the op in WB
// ---------------------------------------------------------------------------
module pipelined_datapath #(
  parameter  int SIZE = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            we,
  input  logic            MuxB_sel,
  input  logic            MuxD_sel,
  input  logic            MuxR_sel,
  input  logic [3:0]      Sel,
  input  logic [RW-1:0]   AA,
  input  logic [RW-1:0]   BA,
  input  logic [RW-1:0]   DA,
  input  logic [SIZE-1:0] PC_in,
  input  logic [SIZE-1:0] Constant_in,
  input  logic [SIZE-1:0] Data_in,
  output logic [SIZE-1:0] Addr_out,
  output logic [SIZE-1:0] Data_out,
  output logic            mem_valid,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_addr,
  output logic            C,
  output logic            V,
  output logic            N,
  output logic            Z
);

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  // EX stage
  logic            ex_valid_q, ex_valid_d;
  logic            ex_we_q,    ex_we_d;
  logic            ex_muxd_q,  ex_muxd_d;
  logic            ex_muxr_q,  ex_muxr_d;
  logic [3:0]      ex_sel_q,   ex_sel_d;
  logic [RW-1:0]   ex_da_q,    ex_da_d;
  logic [SIZE-1:0] ex_a_q,     ex_a_d;     // A operand
  logic [SIZE-1:0] ex_b_q,     ex_b_d;     // B operand after MuxB
  logic [SIZE-1:0] ex_st_q,    ex_st_d;    // reg[BA] regardless of MuxB (store data)
  logic [SIZE-1:0] ex_pc_q,    ex_pc_d;

  // WB stage
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q,    wb_we_d;
  logic            wb_muxd_q,  wb_muxd_d;
  logic            wb_muxr_q,  wb_muxr_d;
  logic [RW-1:0]   wb_da_q,    wb_da_d;
  logic [SIZE-1:0] wb_f_q,     wb_f_d;
  logic [SIZE-1:0] wb_pc_q,    wb_pc_d;
  logic            wb_c_q,     wb_c_d;
  logic            wb_v_q,     wb_v_d;
  logic            wb_n_q,     wb_n_d;
  logic            wb_z_q,     wb_z_d;

  // Register file
  logic [SIZE-1:0] rf_q [NREG];
  logic [SIZE-1:0] rf_d [NREG];

  // Write-back path
  logic            rf_we;
  logic [SIZE-1:0] reg_in;

  // OF-stage combinational values
  logic [SIZE-1:0] a_rd;
  logic [SIZE-1:0] b_rd;
  logic            ex_wr;
  logic            hit_ex;
  logic            stall;
  logic            accept;

  // EX-stage function unit
  logic [SIZE-1:0] fu_y;
  logic            fu_cin;
  logic [SIZE:0]   fu_sum;
  logic [SIZE-1:0] fu_f;
  logic            fu_c;
  logic            fu_v;

  // -------------------------------------------------------------------------
  // WB: result selection and register-file write
  // -------------------------------------------------------------------------
  assign rf_we  = wb_valid_q & wb_we_q;
  assign reg_in = wb_muxr_q ? (wb_muxd_q ? wb_f_q : Data_in) : wb_pc_q;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = (rf_we && (wb_da_q == RW'(i))) ? reg_in : rf_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // OF: operand read, forwarding and hazard detection
  // -------------------------------------------------------------------------
  assign ex_wr = ex_valid_q & ex_we_q;

`ifdef DP_FORWARD_EN
  // An EX op can be forwarded only if its final value is already known in
  // EX: an FU result (MuxD_sel=1) or a PC write (MuxR_sel=0). Loads are not.
  logic            ex_fwd;
  logic [SIZE-1:0] ex_res;
  assign ex_fwd = ex_wr & (ex_muxd_q | ~ex_muxr_q);
  assign ex_res = ex_muxr_q ? fu_f : ex_pc_q;
`endif

  always_comb begin
    a_rd = rf_q[AA];
    b_rd = rf_q[BA];
    // Write-through of the WB write happening this cycle.
    if (rf_we && (wb_da_q == AA)) a_rd = reg_in;
    if (rf_we && (wb_da_q == BA)) b_rd = reg_in;
`ifdef DP_FORWARD_EN
    // EX is the younger producer, so it overrides the WB value.
    if (ex_fwd && (ex_da_q == AA)) a_rd = ex_res;
    if (ex_fwd && (ex_da_q == BA)) b_rd = ex_res;
`endif
  end

  // BA only counts as a source when MuxB selects the register.
  assign hit_ex = ex_wr & ((ex_da_q == AA) | (~MuxB_sel & (ex_da_q == BA)));

`ifdef DP_FORWARD_EN
  // Only a load in EX cannot be forwarded; one cycle later it is in WB and
  // its Data_in is forwarded through Reg_in.
  assign stall = hit_ex & ex_muxr_q & ~ex_muxd_q;
`else
  logic hit_wb;
  assign hit_wb = rf_we & ((wb_da_q == AA) | (~MuxB_sel & (wb_da_q == BA)));
  assign stall  = hit_ex | hit_wb;
`endif

  assign in_ready = ~(in_valid & stall);
  assign accept   = in_valid & in_ready;

  // -------------------------------------------------------------------------
  // EX: function unit
  // Sel 0-7 are all A + Y + cin on one adder; Sel 8-F are logic/shift ops.
  // -------------------------------------------------------------------------
  always_comb begin
    fu_y   = '0;
    fu_cin = 1'b0;
    unique case (ex_sel_q[2:0])
      3'd0: begin fu_y = '0;       fu_cin = 1'b0; end  // A
      3'd1: begin fu_y = '0;       fu_cin = 1'b1; end  // A+1
      3'd2: begin fu_y = ex_b_q;   fu_cin = 1'b0; end  // A+B
      3'd3: begin fu_y = ex_b_q;   fu_cin = 1'b1; end  // A+B+1
      3'd4: begin fu_y = ~ex_b_q;  fu_cin = 1'b0; end  // A+~B
      3'd5: begin fu_y = ~ex_b_q;  fu_cin = 1'b1; end  // A-B
      3'd6: begin fu_y = '1;       fu_cin = 1'b0; end  // A-1
      3'd7: begin fu_y = '0;       fu_cin = 1'b0; end  // A
      default: begin fu_y = '0;    fu_cin = 1'b0; end
    endcase
  end

  assign fu_sum = {1'b0, ex_a_q} + {1'b0, fu_y} + {{SIZE{1'b0}}, fu_cin};

  always_comb begin
    fu_f = '0;
    fu_c = 1'b0;
    fu_v = 1'b0;
    if (!ex_sel_q[3]) begin
      fu_f = fu_sum[SIZE-1:0];
      fu_c = fu_sum[SIZE];
      // Overflow: both addends share a sign and the result sign differs.
      fu_v = (ex_a_q[SIZE-1] == fu_y[SIZE-1]) && (fu_f[SIZE-1] != ex_a_q[SIZE-1]);
    end else begin
      unique case (ex_sel_q[2:0])
        3'd0: fu_f = ex_a_q & ex_b_q;
        3'd1: fu_f = ex_a_q | ex_b_q;
        3'd2: fu_f = ex_a_q ^ ex_b_q;
        3'd3: fu_f = ~ex_a_q;
        3'd4: fu_f = ex_b_q;
        3'd5: fu_f = ex_b_q >> 1;
        3'd6: fu_f = ex_b_q << 1;
        3'd7: fu_f = '0;
        default: fu_f = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    // EX: load on handshake; otherwise a bubble enters with fields held.
    ex_valid_d = accept;
    ex_we_d    = ex_we_q;
    ex_muxd_d  = ex_muxd_q;
    ex_muxr_d  = ex_muxr_q;
    ex_sel_d   = ex_sel_q;
    ex_da_d    = ex_da_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_st_d    = ex_st_q;
    ex_pc_d    = ex_pc_q;
    if (accept) begin
      ex_we_d   = we;
      ex_muxd_d = MuxD_sel;
      ex_muxr_d = MuxR_sel;
      ex_sel_d  = Sel;
      ex_da_d   = DA;
      ex_a_d    = a_rd;
      ex_b_d    = MuxB_sel ? Constant_in : b_rd;
      ex_st_d   = b_rd;
      ex_pc_d   = PC_in;
    end

    // WB: valid follows EX; the payload, wb_addr and flags only change when
    // a real op moves in, so they keep describing the last valid op.
    wb_valid_d = ex_valid_q;
    wb_we_d    = wb_we_q;
    wb_muxd_d  = wb_muxd_q;
    wb_muxr_d  = wb_muxr_q;
    wb_da_d    = wb_da_q;
    wb_f_d     = wb_f_q;
    wb_pc_d    = wb_pc_q;
    wb_c_d     = wb_c_q;
    wb_v_d     = wb_v_q;
    wb_n_d     = wb_n_q;
    wb_z_d     = wb_z_q;
    if (ex_valid_q) begin
      wb_we_d   = ex_we_q;
      wb_muxd_d = ex_muxd_q;
      wb_muxr_d = ex_muxr_q;
      wb_da_d   = ex_da_q;
      wb_f_d    = fu_f;
      wb_pc_d   = ex_pc_q;
      wb_c_d    = fu_c;
      wb_v_d    = fu_v;
      wb_n_d    = fu_f[SIZE-1];
      wb_z_d    = (fu_f == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_muxd_q  <= 1'b0;
      ex_muxr_q  <= 1'b0;
      ex_sel_q   <= '0;
      ex_da_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_st_q    <= '0;
      ex_pc_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_muxd_q  <= 1'b0;
      wb_muxr_q  <= 1'b0;
      wb_da_q    <= '0;
      wb_f_q     <= '0;
      wb_pc_q    <= '0;
      wb_c_q     <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_n_q     <= 1'b0;
      wb_z_q     <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_we_q    <= ex_we_d;
      ex_muxd_q  <= ex_muxd_d;
      ex_muxr_q  <= ex_muxr_d;
      ex_sel_q   <= ex_sel_d;
      ex_da_q    <= ex_da_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_st_q    <= ex_st_d;
      ex_pc_q    <= ex_pc_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_muxd_q  <= wb_muxd_d;
      wb_muxr_q  <= wb_muxr_d;
      wb_da_q    <= wb_da_d;
      wb_f_q     <= wb_f_d;
      wb_pc_q    <= wb_pc_d;
      wb_c_q     <= wb_c_d;
      wb_v_q     <= wb_v_d;
      wb_n_q     <= wb_n_d;
      wb_z_q     <= wb_z_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // With EX cleared by reset, Sel=0 passes A=0, so Addr_out is 0 in reset.
  assign Addr_out  = fu_f;
  assign Data_out  = ex_st_q;
  assign mem_valid = ex_valid_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_da_q;
  assign C         = wb_c_q;
  assign V         = wb_v_q;
  assign N         = wb_n_q;
  assign Z         = wb_z_q;

endmodule
